// File: rtl/dot_acc_pkg.sv
// dot_acc_engine shared definitions.
// State enum, width helpers and signed clamp helpers.
package dot_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_e;

  function automatic int pp_size(
    input int i0,
    input int i1
  );
    return i0 + i1 + 1;
  endfunction

  function automatic int full_size(
    input int i0,
    input int i1,
    input int arr,
    input int ml
  );
    return i0 + i1 + $clog2(arr * ml) + 1;
  endfunction

  function automatic int cnt_size(input int ml);
    return $clog2(ml + 1);
  endfunction

  function automatic logic signed [63:0] sat_max(
    input int w
  );
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic is_sat(
    input logic signed [63:0] v,
    input int w
  );
    return (v > sat_max(w)) || (v < ~sat_max(w));
  endfunction

  function automatic logic signed [63:0] clamp(
    input logic signed [63:0] v,
    input int w
  );
    if (v > sat_max(w)) return sat_max(w);
    if (v < ~sat_max(w)) return ~sat_max(w);
    return v;
  endfunction

endpackage

// File: rtl/dot_acc_if.sv
// dot_acc_engine stream interface.
// Operand beat input and result output handshakes.
interface dot_acc_if #(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_LEN    = 16,
  parameter int ACC_SIZE   = 16
) ();
  import dot_acc_pkg::*;

  localparam int CW = cnt_size(MAX_LEN);

  logic in_valid_i;
  logic in_ready_o;
  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] in_0_i;
  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] in_1_i;
  logic in_last_i;
  logic signed_0_i;
  logic signed_1_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [ACC_SIZE-1:0] out_data_o;
  logic out_sat_o;
  logic out_len_err_o;
  logic [CW-1:0] out_count_o;

  modport master (
    output in_valid_i, in_0_i, in_1_i,
    output in_last_i, signed_0_i, signed_1_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o,
    input  out_data_o, out_sat_o,
    input  out_len_err_o, out_count_o
  );

  modport slave (
    input  in_valid_i, in_0_i, in_1_i,
    input  in_last_i, signed_0_i, signed_1_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o,
    output out_data_o, out_sat_o,
    output out_len_err_o, out_count_o
  );

endinterface

// File: rtl/dot_acc_engine_array.sv
// dot_array_cs: one registered stage of extended
// multipliers reduced to a carry-save pair.
module dot_array_cs
  import dot_acc_pkg::*;
#(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_LEN    = 16,
  localparam int FULL = full_size(IN_SIZE_0,
    IN_SIZE_1, ARRAY_SIZE, MAX_LEN)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vld_i,
  input  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] in_0_i,
  input  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] in_1_i,
  input  logic sgn_0_i,
  input  logic sgn_1_i,
  output logic [FULL-1:0] s_o,
  output logic [FULL-1:0] c_o
);

  localparam int PP = pp_size(IN_SIZE_0, IN_SIZE_1);

  logic signed [IN_SIZE_0:0] a_c;
  logic signed [IN_SIZE_1:0] b_c;
  logic signed [PP-1:0] p_c;
  logic [FULL-1:0] t_c, s_c, c_c, ns_c;

  function automatic logic [FULL-1:0] cy(
    input logic [FULL-1:0] x,
    input logic [FULL-1:0] y,
    input logic [FULL-1:0] z
  );
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // 3:2 compressor chain, one product per step
  always_comb begin
    a_c  = '0;
    b_c  = '0;
    p_c  = '0;
    t_c  = '0;
    s_c  = '0;
    c_c  = '0;
    ns_c = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      a_c  = {sgn_0_i & in_0_i[i][IN_SIZE_0-1],
              in_0_i[i]};
      b_c  = {sgn_1_i & in_1_i[i][IN_SIZE_1-1],
              in_1_i[i]};
      p_c  = PP'(a_c) * PP'(b_c);
      t_c  = FULL'(p_c);
      ns_c = s_c ^ c_c ^ t_c;
      c_c  = cy(s_c, c_c, t_c);
      s_c  = ns_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_o <= '0;
      c_o <= '0;
    end else if (vld_i) begin
      s_o <= s_c;
      c_o <= c_c;
    end
  end

endmodule

// File: rtl/dot_acc_engine.sv
// dot_acc_engine: streaming dot-product accumulator
// with carry-save accumulation and clamped result.
module dot_acc_engine
  import dot_acc_pkg::*;
#(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_LEN    = 16,
  parameter int ACC_SIZE   = 16,
  parameter int SATURATE   = 1
) (
  input logic clk_i,
  input logic rst_ni,
  dot_acc_if.slave bus
);

  localparam int FULL = full_size(IN_SIZE_0,
    IN_SIZE_1, ARRAY_SIZE, MAX_LEN);
  localparam int CW = cnt_size(MAX_LEN);

  state_e state_q, state_d;
  logic rdy_q, take_c, first_c;
  logic close_c, lenerr_c, lenerr_q;
  logic [CW-1:0] cnt_q, cnt_c;
  logic sgn0_q, sgn1_q, sgn0_c, sgn1_c;
  logic pp_vld_q, pp_first_q, pp_last_q;
  logic acc_done_q, sum_vld_q;
  logic [FULL-1:0] pp_s, pp_c;
  logic [FULL-1:0] acc_s_q, acc_c_q;
  logic [FULL-1:0] base_s, base_c;
  logic [FULL-1:0] x_s, x_c, n_s, n_c;
  logic signed [FULL-1:0] sum_q;
  logic signed [63:0] wide_c;
  logic [ACC_SIZE-1:0] data_c, data_q;
  logic sat_q, len_q;
  logic [CW-1:0] count_q;

  function automatic logic [FULL-1:0] cy(
    input logic [FULL-1:0] x,
    input logic [FULL-1:0] y,
    input logic [FULL-1:0] z
  );
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  assign take_c  = bus.in_valid_i & rdy_q;
  assign first_c = (state_q == IDLE);
  assign cnt_c   = first_c ? CW'(1)
                           : cnt_q + CW'(1);
  assign close_c = bus.in_last_i
                 | (cnt_c == CW'(MAX_LEN));
  assign lenerr_c = (cnt_c == CW'(MAX_LEN))
                  & ~bus.in_last_i;
  assign sgn0_c = first_c ? bus.signed_0_i : sgn0_q;
  assign sgn1_c = first_c ? bus.signed_1_i : sgn1_q;

  dot_array_cs #(
    .IN_SIZE_0 (IN_SIZE_0),
    .IN_SIZE_1 (IN_SIZE_1),
    .ARRAY_SIZE(ARRAY_SIZE),
    .MAX_LEN   (MAX_LEN)
  ) u_array (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .vld_i  (take_c),
    .in_0_i (bus.in_0_i),
    .in_1_i (bus.in_1_i),
    .sgn_0_i(sgn0_c),
    .sgn_1_i(sgn1_c),
    .s_o    (pp_s),
    .c_o    (pp_c)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (take_c)
               state_d = close_c ? DRAIN : ACCUM;
      ACCUM: if (take_c && close_c)
               state_d = DRAIN;
      DRAIN: if (sum_vld_q) state_d = OUT;
      OUT:   if (bus.out_ready_i) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE)
              || (state_d == ACCUM);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      lenerr_q <= 1'b0;
      sgn0_q   <= 1'b0;
      sgn1_q   <= 1'b0;
    end else if (take_c) begin
      cnt_q    <= cnt_c;
      lenerr_q <= lenerr_c;
      sgn0_q   <= sgn0_c;
      sgn1_q   <= sgn1_c;
    end
  end

  // 4:2 merge of the product pair into the accumulator
  assign base_s = pp_first_q ? '0 : acc_s_q;
  assign base_c = pp_first_q ? '0 : acc_c_q;
  assign x_s = base_s ^ base_c ^ pp_s;
  assign x_c = cy(base_s, base_c, pp_s);
  assign n_s = x_s ^ x_c ^ pp_c;
  assign n_c = cy(x_s, x_c, pp_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pp_vld_q   <= 1'b0;
      pp_first_q <= 1'b0;
      pp_last_q  <= 1'b0;
      acc_done_q <= 1'b0;
      sum_vld_q  <= 1'b0;
      acc_s_q    <= '0;
      acc_c_q    <= '0;
      sum_q      <= '0;
    end else begin
      pp_vld_q   <= take_c;
      acc_done_q <= pp_vld_q & pp_last_q;
      sum_vld_q  <= acc_done_q;
      if (take_c) begin
        pp_first_q <= first_c;
        pp_last_q  <= close_c;
      end
      if (pp_vld_q) begin
        acc_s_q <= n_s;
        acc_c_q <= n_c;
      end
      if (acc_done_q)
        sum_q <= acc_s_q + acc_c_q;
    end
  end

  assign wide_c = 64'(sum_q);
  assign data_c = (SATURATE != 0)
    ? ACC_SIZE'(clamp(wide_c, ACC_SIZE))
    : ACC_SIZE'(wide_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      sat_q   <= 1'b0;
      len_q   <= 1'b0;
      count_q <= '0;
    end else if (sum_vld_q) begin
      data_q  <= data_c;
      sat_q   <= is_sat(wide_c, ACC_SIZE);
      len_q   <= lenerr_q;
      count_q <= cnt_q;
    end
  end

  assign bus.in_ready_o    = rdy_q;
  assign bus.out_valid_o   = (state_q == OUT);
  assign bus.out_data_o    = data_q;
  assign bus.out_sat_o     = sat_q;
  assign bus.out_len_err_o = len_q;
  assign bus.out_count_o   = count_q;

endmodule

// File: tb/tb_dot_acc_engine.sv
// tb_dot_acc_engine: directed table, corner sequences
// and a randomized run against a behavioural model.
module tb_dot_acc_engine;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  dot_acc_if bus ();
  dot_acc_if bus_w ();

  assign bus_w.in_valid_i  = bus.in_valid_i;
  assign bus_w.in_0_i      = bus.in_0_i;
  assign bus_w.in_1_i      = bus.in_1_i;
  assign bus_w.in_last_i   = bus.in_last_i;
  assign bus_w.signed_0_i  = bus.signed_0_i;
  assign bus_w.signed_1_i  = bus.signed_1_i;
  assign bus_w.out_ready_i = bus.out_ready_i;

  dot_acc_engine #(.SATURATE(1)) u_sat (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  dot_acc_engine #(.SATURATE(0)) u_wrap (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus_w)
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] b;
    logic s0;
    logic s1;
    int nb;
    logic last;
    int data;
    int wrap;
    logic sat;
    logic len;
    int cnt;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];
  int npass = 0;
  int ntot = 0;

  task automatic chk(input string nm,
                     input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  nm, got, exp);
  endtask

  function automatic int ext(input logic [7:0] v,
                             input int w,
                             input logic s);
    if (s && v[w-1]) return int'(v) - (1 << w);
    return int'(v);
  endfunction

  function automatic int wrap16(input int s);
    logic [15:0] w;
    w = s[15:0];
    return int'($signed(w));
  endfunction

  task automatic send_raw(input logic [31:0] a,
                          input logic [63:0] b,
                          input logic last,
                          input logic s0,
                          input logic s1);
    int t;
    t = 0;
    @(negedge clk_i);
    bus.in_0_i     = a;
    bus.in_1_i     = b;
    bus.in_last_i  = last;
    bus.signed_0_i = s0;
    bus.signed_1_i = s1;
    bus.in_valid_i = 1'b1;
    while (!bus.in_ready_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 100) chk("ready_timeout", t, 0);
    @(posedge clk_i);
    #1 bus.in_valid_i = 1'b0;
  endtask

  task automatic send_u(input logic [3:0] a,
                        input logic [7:0] b,
                        input logic last,
                        input logic s0,
                        input logic s1);
    send_raw({8{a}}, {8{b}}, last, s0, s1);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.out_valid_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk({nm, "_lat"}, n, 3);
  endtask

  task automatic check_fields(input string nm,
                              input int data,
                              input int wrap,
                              input logic sat,
                              input logic len,
                              input int cnt);
    chk({nm, "_data"},
        int'($signed(bus.out_data_o)), data);
    chk({nm, "_wrap"},
        int'($signed(bus_w.out_data_o)), wrap);
    chk({nm, "_sat"}, int'(bus.out_sat_o), int'(sat));
    chk({nm, "_wsat"},
        int'(bus_w.out_sat_o), int'(sat));
    chk({nm, "_len"},
        int'(bus.out_len_err_o), int'(len));
    chk({nm, "_cnt"}, int'(bus.out_count_o), cnt);
  endtask

  task automatic handshake();
    bus.out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 bus.out_ready_i = 1'b0;
  endtask

  task automatic check_res(input string nm,
                           input int data,
                           input int wrap,
                           input logic sat,
                           input logic len,
                           input int cnt);
    wait_valid(nm);
    check_fields(nm, data, wrap, sat, len, cnt);
    handshake();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rdy"}, int'(bus.in_ready_o), 0);
    chk({nm, "_vld"}, int'(bus.out_valid_o), 0);
    chk({nm, "_data"}, int'(bus.out_data_o), 0);
    chk({nm, "_flags"},
        int'({bus.out_sat_o, bus.out_len_err_o}), 0);
    chk({nm, "_cnt"}, int'(bus.out_count_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    int bad;
    tbl[0]  = '{4'h8, 8'h80, 1'b1, 1'b1, 1, 1'b1,
                8192, 8192, 1'b0, 1'b0, 1};
    tbl[1]  = '{4'hF, 8'hFF, 1'b0, 1'b0, 1, 1'b1,
                30600, 30600, 1'b0, 1'b0, 1};
    tbl[2]  = '{4'hF, 8'hFF, 1'b1, 1'b1, 1, 1'b1,
                8, 8, 1'b0, 1'b0, 1};
    tbl[3]  = '{4'hF, 8'hFF, 1'b1, 1'b0, 1, 1'b1,
                -2040, -2040, 1'b0, 1'b0, 1};
    tbl[4]  = '{4'hF, 8'hFF, 1'b0, 1'b1, 1, 1'b1,
                -120, -120, 1'b0, 1'b0, 1};
    tbl[5]  = '{4'h8, 8'h80, 1'b1, 1'b1, 16, 1'b1,
                32767, 0, 1'b1, 1'b0, 16};
    tbl[6]  = '{4'h8, 8'h7F, 1'b1, 1'b1, 16, 1'b1,
                -32768, 1024, 1'b1, 1'b0, 16};
    tbl[7]  = '{4'h1, 8'h01, 1'b1, 1'b1, 16, 1'b0,
                128, 128, 1'b0, 1'b1, 16};
    tbl[8]  = '{4'h1, 8'h01, 1'b1, 1'b1, 1, 1'b1,
                8, 8, 1'b0, 1'b0, 1};
    tbl[9]  = '{4'h3, 8'h05, 1'b0, 1'b0, 3, 1'b1,
                360, 360, 1'b0, 1'b0, 3};
    tbl[10] = '{4'hF, 8'hFF, 1'b0, 1'b0, 2, 1'b1,
                32767, -4336, 1'b1, 1'b0, 2};

    bus.in_valid_i  = 1'b0;
    bus.in_0_i      = '0;
    bus.in_1_i      = '0;
    bus.in_last_i   = 1'b0;
    bus.signed_0_i  = 1'b0;
    bus.signed_1_i  = 1'b0;
    bus.out_ready_i = 1'b0;

    #1 rst_ni = 1'b0;
    #30;
    check_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("rdy_pre_edge", int'(bus.in_ready_o), 0);
    @(posedge clk_i);
    #1 chk("rdy_post_edge", int'(bus.in_ready_o), 1);

    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < tbl[k].nb; i++)
        send_u(tbl[k].a, tbl[k].b,
               tbl[k].last && (i == tbl[k].nb - 1),
               tbl[k].s0, tbl[k].s1);
      check_res($sformatf("vec%0d", k),
                tbl[k].data, tbl[k].wrap,
                tbl[k].sat, tbl[k].len, tbl[k].cnt);
    end

    send_u(4'hF, 8'hFF, 1'b0, 1'b1, 1'b1);
    send_u(4'hF, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_u(4'hF, 8'hFF, 1'b1, 1'b0, 1'b1);
    check_res("mode_hold_s", 24, 24, 1'b0, 1'b0, 3);
    send_u(4'hF, 8'h01, 1'b0, 1'b0, 1'b0);
    send_u(4'hF, 8'h01, 1'b1, 1'b1, 1'b1);
    check_res("mode_hold_u", 240, 240, 1'b0, 1'b0, 2);

    send_u(4'h8, 8'h80, 1'b1, 1'b1, 1'b1);
    wait_valid("bp");
    bus.in_0_i     = {8{4'h1}};
    bus.in_1_i     = {8{8'h01}};
    bus.in_last_i  = 1'b1;
    bus.signed_0_i = 1'b1;
    bus.signed_1_i = 1'b1;
    bus.in_valid_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (bus.out_data_o != 16'd8192 ||
          !bus.out_valid_o || bus.in_ready_o ||
          bus.out_sat_o || bus.out_len_err_o ||
          bus.out_count_o != 5'd1)
        bad++;
    end
    chk("bp_hold", bad, 0);
    @(negedge clk_i);
    handshake();
    chk("bp_rdy_after", int'(bus.in_ready_o), 1);
    chk("bp_vld_drop", int'(bus.out_valid_o), 0);
    @(posedge clk_i);
    #1 bus.in_valid_i = 1'b0;
    check_res("bp_next", 8, 8, 1'b0, 1'b0, 1);

    for (int i = 0; i < 3; i++)
      send_u(4'h1, 8'h01, 1'b0, 1'b1, 1'b1);
    #2 rst_ni = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk_i);
    rst_ni = 1'b1;
    send_u(4'h1, 8'h01, 1'b1, 1'b1, 1'b1);
    wait_valid("rst_fresh");
    check_fields("rst_fresh", 8, 8, 1'b0, 1'b0, 1);
    #2 rst_ni = 1'b0;
    #1 check_zero("rst_pend");
    @(negedge clk_i);
    rst_ni = 1'b1;
    send_u(4'h2, 8'h03, 1'b1, 1'b1, 1'b1);
    check_res("rst_after", 48, 48, 1'b0, 1'b0, 1);

    for (int t = 0; t < 100; t++) begin
      int nb, sum, ed;
      logic s0, s1, noend, sat;
      logic [31:0] a;
      logic [63:0] b;
      nb    = $urandom_range(1, 16);
      s0    = 1'($urandom_range(0, 1));
      s1    = 1'($urandom_range(0, 1));
      noend = (nb == 16) && ($urandom_range(0, 3) == 0);
      sum   = 0;
      for (int i = 0; i < nb; i++) begin
        a = $urandom;
        b = {$urandom, $urandom};
        for (int e = 0; e < 8; e++)
          sum += ext({4'b0, a[e*4+:4]}, 4, s0)
               * ext(b[e*8+:8], 8, s1);
        if (i == 0)
          send_raw(a, b, (i == nb - 1) && !noend,
                   s0, s1);
        else
          send_raw(a, b, (i == nb - 1) && !noend,
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end
      sat = (sum > 32767) || (sum < -32768);
      ed  = !sat ? sum : (sum > 0 ? 32767 : -32768);
      check_res($sformatf("rnd%0d", t), ed,
                wrap16(sum), sat, noend, nb);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
